// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between two requesters
//   (req0: ALU writeback, req1: load/debug loader) using valid/ready handshakes.
//   One winner per cycle; the winning write is registered onto the port in the
//   following cycle. Writes to register $0 are accepted but discarded.
//
// Build option:
//   RR_ARB_EN  defined   -> round-robin on contention (requester != lastGrant wins)
//              undefined -> fixed priority, requester 0 wins on contention
//
// Ports:
//   clock_in, reset                 clock (rising edge), async active-high reset
//   reqN_valid/reqN_reg/reqN_data   requester N write request
//   reqN_ready                      requester N accepted this cycle (combinational)
//   regWrite/writeReg/writeData     register file write port
//   grant_id                        source of the write currently on the port
//   wr_count0/wr_count1/drop_count  saturating statistics counters
//
// FSM states (what the output stage presents):
//   IDLE   | no write on the port; writeReg/writeData hold last values
//   ISSUE0 | write captured from requester 0 on the port
//   ISSUE1 | write captured from requester 1 on the port
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              grant_id,
    output logic [CNT_W-1:0]  wr_count0,
    output logic [CNT_W-1:0]  wr_count1,
    output logic [CNT_W-1:0]  drop_count
);

`ifdef RR_ARB_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE0 = 2'd1,
        ISSUE1 = 2'd2
    } state_t;

    state_t             stateQ;
    state_t             stateD;
    logic               lastGrant;
    logic               grant0;
    logic               grant1;
    logic               transfer;
    logic               selIsZero;
    logic [ADDR_W-1:0]  selReg;
    logic [DATA_W-1:0]  selData;
    logic               dropQ;
    logic [ADDR_W-1:0]  writeRegQ;
    logic [DATA_W-1:0]  writeDataQ;
    logic               grantIdQ;
    logic [CNT_W-1:0]   cnt0Q;
    logic [CNT_W-1:0]   cnt1Q;
    logic [CNT_W-1:0]   dropCntQ;

    localparam logic [CNT_W-1:0] CntMax = '1;

    // Arbitration and next state. Grants are suppressed during reset so that
    // neither ready can be seen high while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        stateD = IDLE;
        if (!reset) begin
            if (req0_valid && req1_valid) begin
                // Fixed-priority builds always take requester 0; round-robin
                // builds take whichever did not win the previous transfer.
                if (!RoundRobin || lastGrant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
        if (grant0) begin
            stateD = ISSUE0;
        end else if (grant1) begin
            stateD = ISSUE1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign transfer   = grant0 | grant1;
    assign selReg     = grant1 ? req1_reg  : req0_reg;
    assign selData    = grant1 ? req1_data : req0_data;
    assign selIsZero  = (selReg == '0);

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Output stage capture. A $0 write still moves the FSM to ISSUEk but is
    // flagged so the port stays disabled and the previous index/data hold.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            lastGrant  <= 1'b1;
            dropQ      <= 1'b0;
            writeRegQ  <= '0;
            writeDataQ <= '0;
            grantIdQ   <= 1'b0;
        end else if (transfer) begin
            lastGrant <= grant1;
            grantIdQ  <= grant1;
            dropQ     <= selIsZero;
            if (!selIsZero) begin
                writeRegQ  <= selReg;
                writeDataQ <= selData;
            end
        end
    end

    // Counters advance at the accepting edge, saturating at all-ones.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cnt0Q    <= '0;
            cnt1Q    <= '0;
            dropCntQ <= '0;
        end else if (transfer) begin
            if (selIsZero) begin
                if (dropCntQ != CntMax) dropCntQ <= dropCntQ + 1'b1;
            end else if (grant0) begin
                if (cnt0Q != CntMax) cnt0Q <= cnt0Q + 1'b1;
            end else begin
                if (cnt1Q != CntMax) cnt1Q <= cnt1Q + 1'b1;
            end
        end
    end

    // regWrite is decoded from the async-reset state so it falls the moment
    // reset rises, discarding any captured but uncommitted write.
    assign regWrite   = (stateQ != IDLE) && !dropQ;
    assign writeReg   = writeRegQ;
    assign writeData  = writeDataQ;
    assign grant_id   = grantIdQ;
    assign wr_count0  = cnt0Q;
    assign wr_count1  = cnt1Q;
    assign drop_count = dropCntQ;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

`ifdef RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clock_in = 1'b0;
    logic              reset;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              grant_id;
    logic [CNT_W-1:0]  wr_count0;
    logic [CNT_W-1:0]  wr_count1;
    logic [CNT_W-1:0]  drop_count;

    int passCount  = 0;
    int checkCount = 0;
    int highCycles;
    logic expGid;

    regfile_write_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .req0_valid(req0_valid),
        .req0_reg  (req0_reg),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_reg  (req1_reg),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .grant_id  (grant_id),
        .wr_count0 (wr_count0),
        .wr_count1 (wr_count1),
        .drop_count(drop_count)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic idleInputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0;
        req0_reg   = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_reg   = '0;
        req1_data  = '0;

        // Reset state, with both requesters asserting valid
        repeat (2) @(posedge clock_in);
        @(negedge clock_in);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_regWrite", regWrite, 0);
        check("rst_writeReg", writeReg, 0);
        check("rst_writeData", writeData, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_counters", {wr_count0, wr_count1, drop_count}, 0);
        idleInputs();
        reset = 1'b0;

        // Single req0 write: reg 21, FFFF0000
        @(negedge clock_in);
        req0_valid = 1'b1;
        req0_reg   = 5'd21;
        req0_data  = 32'hFFFF0000;
        #1;
        check("t2_ready0", req0_ready, 1);
        check("t2_ready1", req1_ready, 0);
        @(posedge clock_in);
        #1;
        req0_valid = 1'b0;
        check("t2_regWrite", regWrite, 1);
        check("t2_writeReg", writeReg, 21);
        check("t2_writeData", writeData, 32'hFFFF0000);
        check("t2_grant_id", grant_id, 0);
        check("t2_wr_count0", wr_count0, 1);
        @(negedge clock_in);
        check("t2_regWrite_mid", regWrite, 1);
        @(posedge clock_in);
        #1;
        check("t2_idle_regWrite", regWrite, 0);
        check("t2_idle_hold_reg", writeReg, 21);
        check("t2_idle_hold_data", writeData, 32'hFFFF0000);

        // Contention: both valid for four consecutive transfers
        pulseReset();
        req0_reg  = 5'd10;
        req0_data = 32'h0000FFFF;
        req1_reg  = 5'd5;
        req1_data = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_in);
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            expGid = RR ? i[0] : 1'b0;
            #1;
            check($sformatf("t3_ready0_%0d", i), req0_ready, !expGid);
            check($sformatf("t3_ready1_%0d", i), req1_ready, expGid);
            @(posedge clock_in);
            #1;
            check($sformatf("t3_regWrite_%0d", i), regWrite, 1);
            check($sformatf("t3_grant_id_%0d", i), grant_id, expGid);
            check($sformatf("t3_writeReg_%0d", i), writeReg, expGid ? 5 : 10);
            check($sformatf("t3_writeData_%0d", i), writeData, expGid ? 32'h12345678 : 32'h0000FFFF);
        end
        idleInputs();
        check("t3_wr_count0", wr_count0, RR ? 2 : 4);
        check("t3_wr_count1", wr_count1, RR ? 2 : 0);

        // req1 write to $0 is accepted and dropped
        @(negedge clock_in);
        req1_valid = 1'b1;
        req1_reg   = 5'd0;
        req1_data  = 32'hDEADBEEF;
        #1;
        check("t4_ready1", req1_ready, 1);
        check("t4_ready0", req0_ready, 0);
        @(posedge clock_in);
        #1;
        req1_valid = 1'b0;
        check("t4_regWrite", regWrite, 0);
        check("t4_drop_count", drop_count, 1);
        check("t4_wr_count1", wr_count1, RR ? 2 : 0);
        check("t4_wr_count0", wr_count0, RR ? 2 : 4);

        // 20 back-to-back req0 writes to reg 3; counter saturates at 15
        pulseReset();
        @(negedge clock_in);
        req0_valid = 1'b1;
        req0_reg   = 5'd3;
        req0_data  = 32'h00000333;
        highCycles = 0;
        for (int i = 0; i < 22; i++) begin
            @(posedge clock_in);
            #1;
            if (i == 19) req0_valid = 1'b0;
            if (regWrite) highCycles++;
            if (i == 14) check("t5_count_at_15", wr_count0, 15);
        end
        check("t5_high_cycles", highCycles, 20);
        check("t5_wr_count0_sat", wr_count0, 15);
        check("t5_drop_count", drop_count, 0);

        // Async reset while ISSUE1 is presented
        @(negedge clock_in);
        req1_valid = 1'b1;
        req1_reg   = 5'd7;
        req1_data  = 32'hA5A5A5A5;
        @(posedge clock_in);
        #1;
        req1_valid = 1'b0;
        check("t6_issue1_regWrite", regWrite, 1);
        check("t6_issue1_grant_id", grant_id, 1);
        #1;
        reset      = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_reg   = 5'd10;
        req0_data  = 32'h0000FFFF;
        #1;
        check("t6_rst_regWrite", regWrite, 0);
        check("t6_rst_grant_id", grant_id, 0);
        check("t6_rst_writeReg", writeReg, 0);
        check("t6_rst_writeData", writeData, 0);
        check("t6_rst_counters", {wr_count0, wr_count1, drop_count}, 0);
        check("t6_rst_readies", {req0_ready, req1_ready}, 0);
        #2;
        reset = 1'b0;
        #1;
        check("t6_post_ready0", req0_ready, 1);
        check("t6_post_ready1", req1_ready, 0);
        @(posedge clock_in);
        #1;
        idleInputs();
        check("t6_post_grant_id", grant_id, 0);
        check("t6_post_writeReg", writeReg, 10);
        check("t6_post_wr_count0", wr_count0, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1);
    end

endmodule
